// File: rtl/scan_sequencer_if.sv
// Scan chain pin bundle between the sequencer (master) and the first chain stage (slave).
interface scan_sequencer_if;
  logic scan_clk_out;
  logic scan_data_out;
  logic scan_select;
  logic scan_latch_en;
  logic scan_clk_in;
  logic scan_data_in;

  modport master (
    output scan_clk_out,
    output scan_data_out,
    output scan_select,
    output scan_latch_en,
    input  scan_clk_in,
    input  scan_data_in
  );

  modport slave (
    input  scan_clk_out,
    input  scan_data_out,
    input  scan_select,
    input  scan_latch_en,
    output scan_clk_in,
    output scan_data_in
  );
endinterface

// File: rtl/scan_sequencer.sv
// Scan chain sequencer: capture all stage outputs, shift new inputs into one target stage while
// reading its outputs back, then latch. One transaction per accepted start.
module scan_sequencer #(
  parameter int unsigned NUM_DESIGNS = 249,
  parameter int unsigned NUM_IOS     = 8,
  parameter int unsigned HALF        = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [8:0]         active_select,
  input  logic [NUM_IOS-1:0] inputs,
  output logic [NUM_IOS-1:0] outputs,
  output logic               busy,
  output logic               done,
  output logic               error,
  scan_sequencer_if.master   scan
);

  localparam int unsigned TotalBits = NUM_DESIGNS * NUM_IOS;
  localparam int unsigned StepW     = $clog2(TotalBits + 1);
  localparam int unsigned PhaseW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned IdxW      = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(HALF - 1);
  localparam logic [StepW-1:0]  StepLast  = StepW'(TotalBits - 1);
  localparam logic [StepW-1:0]  IosW      = StepW'(NUM_IOS);

  typedef enum logic [2:0] {StIdle, StReject, StCapture, StShift, StLatch, StDone} state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   ph_q, ph_d;
  logic                clk_q, clk_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [StepW-1:0]    base_q, base_d;
  logic [NUM_IOS-1:0]  tgt_q, tgt_d;
  logic [NUM_IOS-1:0]  shadow_q, shadow_d;
  logic [NUM_IOS-1:0]  outputs_q, outputs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                sel_q, sel_d;
  logic                latch_q, latch_d;
  logic                data_q, data_d;

  logic                sel_valid, ph_last, step_last;
  logic [StepW-1:0]    diff_q, diff_n;
  logic                hit_q, hit_n;
  logic [IdxW-1:0]     j_q, j_n;
  logic                unused_scan_clk_in;

  assign unused_scan_clk_in = scan.scan_clk_in;

  assign sel_valid = 32'(active_select) < NUM_DESIGNS;
  assign ph_last   = (ph_q == PhaseLast);
  assign step_last = (step_q == StepLast);

  // Target bit j of stage k sits at shift step base - j, where base = T-1-NUM_IOS*k.
  assign diff_q = base_q - step_q;
  assign hit_q  = (step_q <= base_q) && (diff_q < IosW);
  assign j_q    = diff_q[IdxW-1:0];
  assign diff_n = base_q - step_d;
  assign hit_n  = (step_d <= base_q) && (diff_n < IosW);
  assign j_n    = diff_n[IdxW-1:0];

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    clk_d    = clk_q;
    step_d   = step_q;
    base_d   = base_q;
    tgt_d    = tgt_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (sel_valid) begin
            state_d = StCapture;
            base_d  = StepLast - StepW'(NUM_IOS * 32'(active_select));
            tgt_d   = inputs;
            ph_d    = '0;
            clk_d   = 1'b0;
          end else begin
            state_d = StReject;
          end
        end
      end
      StReject: state_d = StIdle;
      StCapture, StShift: begin
        if (!ph_last) begin
          ph_d = ph_q + PhaseW'(1);
        end else begin
          ph_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
            // Chain output is stable here: it last moved on the falling scan clock.
            if (state_q == StShift && hit_q) shadow_d[j_q] = scan.scan_data_in;
          end else begin
            clk_d = 1'b0;
            if (state_q == StCapture) begin
              state_d = StShift;
              step_d  = '0;
            end else if (step_last) begin
              state_d = StLatch;
            end else begin
              step_d = step_q + StepW'(1);
            end
          end
        end
      end
      StLatch: begin
        if (!ph_last) begin
          ph_d = ph_q + PhaseW'(1);
        end else begin
          ph_d    = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so every pin comes straight off a flop.
  always_comb begin
    busy_d    = (state_d == StCapture) || (state_d == StShift) || (state_d == StLatch);
    done_d    = (state_d == StReject) || (state_d == StDone);
    sel_d     = (state_d == StCapture);
    latch_d   = (state_d == StLatch);
    outputs_d = (state_d == StDone) ? shadow_q : outputs_q;
    error_d   = error_q;
    if (state_d == StReject) begin
      error_d = 1'b1;
    end else if (state_d == StDone) begin
      error_d = 1'b0;
    end
    data_d = 1'b0;
    if (state_d == StShift) begin
      if (clk_d) begin
        data_d = data_q;
      end else if (hit_n) begin
        data_d = tgt_q[j_n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ph_q      <= '0;
      clk_q     <= 1'b0;
      step_q    <= '0;
      base_q    <= '0;
      tgt_q     <= '0;
      shadow_q  <= '0;
      outputs_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      sel_q     <= 1'b0;
      latch_q   <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      clk_q     <= clk_d;
      step_q    <= step_d;
      base_q    <= base_d;
      tgt_q     <= tgt_d;
      shadow_q  <= shadow_d;
      outputs_q <= outputs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      sel_q     <= sel_d;
      latch_q   <= latch_d;
      data_q    <= data_d;
    end
  end

  assign outputs            = outputs_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign scan.scan_clk_out  = clk_q;
  assign scan.scan_data_out = data_q;
  assign scan.scan_select   = sel_q;
  assign scan.scan_latch_en = latch_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: 4-stage behavioural chain (stage 0 inverts, others loop back)
// on a HALF=1 instance, plus a bare HALF=3 instance for scan clock timing.
module tb_scan_sequencer;
  localparam int unsigned T = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // HALF=1 instance with chain model
  logic       start = 1'b0;
  logic [8:0] active_select = '0;
  logic [7:0] inputs = '0;
  logic [7:0] outputs;
  logic       busy, done, error;
  scan_sequencer_if sif ();

  scan_sequencer #(.NUM_DESIGNS(4), .NUM_IOS(8), .HALF(1)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .active_select (active_select),
    .inputs        (inputs),
    .outputs       (outputs),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .scan          (sif)
  );

  logic [T-1:0] chain = '0;
  logic [T-1:0] latched_v = '0;
  logic [T-1:0] cap_vec;
  assign cap_vec = {latched_v[T-1:8], ~latched_v[7:0]};
  assign sif.scan_clk_in = sif.scan_clk_out;

  always @(posedge sif.scan_clk_out) begin
    if (sif.scan_select) chain <= cap_vec;
    else chain <= {chain[T-2:0], sif.scan_data_out};
  end
  always @(negedge sif.scan_clk_out) sif.scan_data_in <= chain[T-1];
  always @(posedge sif.scan_latch_en) latched_v <= chain;

  int sclk_edges = 0;
  always @(posedge sif.scan_clk_out) sclk_edges <= sclk_edges + 1;

  // HALF=3 instance, chain data tied low
  logic       h_start = 1'b0;
  logic [8:0] h_sel = '0;
  logic [7:0] h_inputs = '0;
  logic [7:0] h_outputs;
  logic       h_busy, h_done, h_error;
  scan_sequencer_if sif3 ();
  assign sif3.scan_data_in = 1'b0;
  assign sif3.scan_clk_in  = sif3.scan_clk_out;

  scan_sequencer #(.NUM_DESIGNS(4), .NUM_IOS(8), .HALF(3)) u_dut3 (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (h_start),
    .active_select (h_sel),
    .inputs        (h_inputs),
    .outputs       (h_outputs),
    .busy          (h_busy),
    .done          (h_done),
    .error         (h_error),
    .scan          (sif3)
  );

  // Launch one request from IDLE and follow it to its done pulse; returns one cycle after done.
  task automatic run1(input logic [8:0] sel, input logic [7:0] din, output int dcyc,
                      output int busy_bad, output logic err_pre, output logic err_done);
    active_select = sel;
    inputs        = din;
    start         = 1'b1;
    err_pre       = error;
    @(posedge clk); #1;
    start    = 1'b0;
    dcyc     = 0;
    busy_bad = 0;
    err_done = 1'bx;
    for (int c = 1; c <= 150; c++) begin
      if (done === 1'b1) begin
        dcyc     = c;
        err_done = error;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      err_pre = error;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (outputs !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %h, expected 00", outputs);
    end
    n_vec++;
    if ({busy, done, error} !== 3'b000) begin
      n_err++; $display("FAIL reset_status: got %b, expected 000", {busy, done, error});
    end
    n_vec++;
    if ({sif.scan_clk_out, sif.scan_data_out, sif.scan_select, sif.scan_latch_en} !== 4'b0000)
    begin
      n_err++;
      $display("FAIL reset_scan_pins: got %b, expected 0000", {sif.scan_clk_out,
               sif.scan_data_out, sif.scan_select, sif.scan_latch_en});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, sif3.scan_clk_out, h_busy} !== 4'b0000) begin
      n_err++; $display("FAIL idle_after_reset: got %b, expected 0000",
                        {busy, done, sif3.scan_clk_out, h_busy});
    end
  endtask

  task automatic test_sel0_inverter();
    int dcyc, bb, e0;
    logic ep, ed;
    e0 = sclk_edges;
    run1(9'd0, 8'hA5, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 68) begin n_err++; $display("FAIL sel0_done_cycle_1: got %0d, expected 68", dcyc); end
    n_vec++;
    if (bb !== 0) begin n_err++; $display("FAIL sel0_busy_profile_1: got %0d bad, expected 0", bb); end
    n_vec++;
    if (outputs !== 8'hFF) begin
      n_err++; $display("FAIL sel0_outputs_1: got %h, expected ff", outputs);
    end
    n_vec++;
    if (sclk_edges - e0 !== 33) begin
      n_err++; $display("FAIL sel0_scan_pulses: got %0d, expected 33", sclk_edges - e0);
    end
    run1(9'd0, 8'hA5, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 68) begin n_err++; $display("FAIL sel0_done_cycle_2: got %0d, expected 68", dcyc); end
    n_vec++;
    if (bb !== 0) begin n_err++; $display("FAIL sel0_busy_profile_2: got %0d bad, expected 0", bb); end
    n_vec++;
    if (outputs !== 8'h5A) begin
      n_err++; $display("FAIL sel0_outputs_2: got %h, expected 5a", outputs);
    end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL sel0_done_one_cycle: got %b, expected 0", done); end
  endtask

  task automatic test_sel1_loopback();
    int dcyc, bb;
    logic ep, ed;
    run1(9'd1, 8'h3C, dcyc, bb, ep, ed);
    run1(9'd1, 8'hC3, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 68) begin n_err++; $display("FAIL sel1_done_cycle: got %0d, expected 68", dcyc); end
    n_vec++;
    if (outputs !== 8'h3C) begin
      n_err++; $display("FAIL sel1_outputs: got %h, expected 3c", outputs);
    end
    n_vec++;
    if (latched_v[7:0] !== 8'h00) begin
      n_err++; $display("FAIL sel1_stage0_zeroed: got %h, expected 00", latched_v[7:0]);
    end
    n_vec++;
    if (latched_v[15:8] !== 8'hC3) begin
      n_err++; $display("FAIL sel1_stage1_loaded: got %h, expected c3", latched_v[15:8]);
    end
  endtask

  task automatic test_reject();
    int dcyc, bb, e0;
    logic ep, ed;
    e0 = sclk_edges;
    run1(9'd4, 8'h11, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 1) begin n_err++; $display("FAIL reject_done_cycle: got %0d, expected 1", dcyc); end
    n_vec++;
    if (ed !== 1'b1) begin n_err++; $display("FAIL reject_error: got %b, expected 1", ed); end
    n_vec++;
    if (sclk_edges - e0 !== 0) begin
      n_err++; $display("FAIL reject_no_scan_clk: got %0d, expected 0", sclk_edges - e0);
    end
    n_vec++;
    if ({error, busy, done} !== 3'b100) begin
      n_err++; $display("FAIL reject_error_holds: got %b, expected 100", {error, busy, done});
    end
  endtask

  task automatic test_sel3_last_stage();
    int dcyc, bb;
    logic ep, ed;
    run1(9'd3, 8'h81, dcyc, bb, ep, ed);
    n_vec++;
    if (ep !== 1'b1) begin n_err++; $display("FAIL sel3_error_before_done: got %b, expected 1", ep); end
    n_vec++;
    if (ed !== 1'b0) begin n_err++; $display("FAIL sel3_error_cleared: got %b, expected 0", ed); end
    run1(9'd3, 8'h81, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 68) begin n_err++; $display("FAIL sel3_done_cycle: got %0d, expected 68", dcyc); end
    n_vec++;
    if (outputs !== 8'h81) begin
      n_err++; $display("FAIL sel3_outputs: got %h, expected 81", outputs);
    end
  endtask

  task automatic test_reset_mid_shift();
    int dcyc, bb;
    logic ep, ed;
    active_select = 9'd3;
    inputs        = 8'h81;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, outputs} !== {1'b1, 8'h81}) begin
      n_err++; $display("FAIL mid_shift_state: got %b/%h, expected 1/81", busy, outputs);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (outputs !== 8'h00) begin
      n_err++; $display("FAIL async_reset_outputs: got %h, expected 00", outputs);
    end
    n_vec++;
    if ({busy, done, error, sif.scan_clk_out, sif.scan_data_out, sif.scan_select,
         sif.scan_latch_en} !== 7'b0) begin
      n_err++;
      $display("FAIL async_reset_pins: got %b, expected 0000000", {busy, done, error,
               sif.scan_clk_out, sif.scan_data_out, sif.scan_select, sif.scan_latch_en});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run1(9'd3, 8'h81, dcyc, bb, ep, ed);
    n_vec++;
    if (dcyc !== 68) begin
      n_err++; $display("FAIL post_reset_done_cycle: got %0d, expected 68", dcyc);
    end
    n_vec++;
    if (outputs !== 8'h81) begin
      n_err++; $display("FAIL post_reset_outputs: got %h, expected 81", outputs);
    end
  endtask

  task automatic test_half3();
    int dcyc, n_done, n_hi, bad_hi, bad_lo, bad_ov, n_latch, run_len, busy_after;
    logic prev;
    dcyc = 0; n_done = 0; n_hi = 0; bad_hi = 0; bad_lo = 0; bad_ov = 0;
    n_latch = 0; run_len = 0; busy_after = 0; prev = 1'b0;
    h_sel    = 9'd2;
    h_inputs = 8'h5A;
    h_start  = 1'b1;
    @(posedge clk); #1;
    h_start = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      if (sif3.scan_clk_out === prev) begin
        run_len++;
      end else begin
        if (prev) begin
          n_hi++;
          if (run_len != 3) bad_hi++;
        end else if (run_len != 3) begin
          bad_lo++;
        end
        run_len = 1;
      end
      prev = sif3.scan_clk_out;
      if (sif3.scan_latch_en && sif3.scan_clk_out) bad_ov++;
      if (sif3.scan_latch_en) n_latch++;
      if (h_done) begin
        n_done++;
        if (dcyc == 0) dcyc = c;
      end
      if (c > 202 && h_busy) busy_after++;
      h_start = (c == 10) || (c == 100);
      @(posedge clk); #1;
    end
    h_start = 1'b0;
    n_vec++;
    if (dcyc !== 202) begin n_err++; $display("FAIL h3_done_cycle: got %0d, expected 202", dcyc); end
    n_vec++;
    if (n_done !== 1) begin n_err++; $display("FAIL h3_start_ignored: got %0d done, expected 1", n_done); end
    n_vec++;
    if (busy_after !== 0) begin
      n_err++; $display("FAIL h3_no_requeue: got %0d busy cycles, expected 0", busy_after);
    end
    n_vec++;
    if (n_hi !== 33) begin n_err++; $display("FAIL h3_pulse_count: got %0d, expected 33", n_hi); end
    n_vec++;
    if (bad_hi !== 0 || bad_lo !== 0) begin
      n_err++; $display("FAIL h3_half_period: got %0d/%0d bad high/low runs, expected 0/0",
                        bad_hi, bad_lo);
    end
    n_vec++;
    if (bad_ov !== 0) begin n_err++; $display("FAIL h3_latch_overlap: got %0d, expected 0", bad_ov); end
    n_vec++;
    if (n_latch !== 3) begin n_err++; $display("FAIL h3_latch_len: got %0d, expected 3", n_latch); end
  endtask

  initial begin
    test_reset();
    test_sel0_inverter();
    test_sel1_loopback();
    test_reject();
    test_sel3_last_stage();
    test_reset_mid_shift();
    test_half3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
